// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, RX FIFO depth, RX data register offset
// and the RX FIFO level type.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;
  localparam int unsigned UART_RX_FIFO_AW    = $clog2(UART_RX_FIFO_DEPTH);
  localparam logic [7:0]  UART_RX_DATA_OFFSET = 8'h03;

  typedef logic [UART_RX_FIFO_AW:0] uart_rx_level_t;

endpackage

// File: rtl/uart_rx_fifo_timer.sv
// Idle counter for the RX FIFO: raises timeout_o once a non-empty FIFO has seen
// no push or pop for limit_i cycles. Built only under UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             activity_i,
  input  logic             empty_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             clear;

  always_comb begin
    clear     = activity_i || empty_i || (limit_i == '0);
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (clear) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      // Saturate so a long idle period never wraps back below the limit.
      if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_q >= limit_i) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX byte FIFO between UART receiver and APB register file.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_W = UART_DATA_W,
  parameter  int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level,
  input  logic [AW:0]       thresh,
  output logic              thresh_hit,
  output logic              overrun,
  input  logic              ovr_clr,
  input  logic [31:0]       timeout_cycles,
  output logic              timeout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_d;
  logic              thresh_hit_q, thresh_hit_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  always_comb begin
    pop  = rd_req && !empty;
    // A full FIFO still accepts when a pop frees a slot in the same cycle.
    push = wr_valid && (!full || rd_req);
    drop = wr_valid && full && !rd_req;

    wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
    level_d      = wr_ptr_d - rd_ptr_d;
    thresh_hit_d = (thresh != '0) && (level_d >= thresh);
    overrun_d    = (overrun_q && !ovr_clr) || drop;
  end

  always_ff @(posedge PCLK) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      thresh_hit_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      thresh_hit_q <= thresh_hit_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign thresh_hit = thresh_hit_q;
  assign overrun    = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  uart_rx_fifo_timer #(
    .CNT_W (32)
  ) u_timer (
    .clk_i      (PCLK),
    .rst_i      (rst),
    .activity_i (push || pop),
    .empty_i    (empty),
    .limit_i    (timeout_cycles),
    .timeout_o  (timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^timeout_cycles;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: popped bytes are scoreboarded against a
// queue of hand-computed expectations; status outputs are checked inline.
module tb_uart_rx_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          PCLK = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          empty, full;
  logic [AW:0]   level;
  logic [AW:0]   thresh;
  logic          thresh_hit, overrun, ovr_clr, timeout;
  logic [31:0]   timeout_cycles;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  uart_rx_fifo #(
    .DATA_W (DW),
    .DEPTH  (16)
  ) dut (
    .PCLK           (PCLK),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .rd_req         (rd_req),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .thresh         (thresh),
    .thresh_hit     (thresh_hit),
    .overrun        (overrun),
    .ovr_clr        (ovr_clr),
    .timeout_cycles (timeout_cycles),
    .timeout        (timeout)
  );

  always #5 PCLK = ~PCLK;

  // Monitor: rd_data is sampled in the same cycle rd_req is raised.
  always @(negedge PCLK) begin
    if (!rst && rd_req && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %02h, no pop expected", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h expected %02h", rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic oc);
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    ovr_clr  = oc;
    @(posedge PCLK);
    #1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic [DW-1:0] e);
    exp_q.push_back(e);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},      empty,      1);
    chk({tag, "_full"},       full,       0);
    chk({tag, "_level"},      level,      0);
    chk({tag, "_rd_data"},    rd_data,    0);
    chk({tag, "_thresh_hit"}, thresh_hit, 0);
    chk({tag, "_overrun"},    overrun,    0);
    chk({tag, "_timeout"},    timeout,    0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; ovr_clr = 1'b0;
    thresh = '0; timeout_cycles = '0;
    repeat (2) @(posedge PCLK);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Single byte round trip
    push(8'hA1);
    chk("a1_rd_data", rd_data, 8'hA1);
    chk("a1_level",   level,   1);
    chk("a1_empty",   empty,   0);
    pop(8'hA1);
    chk("a1_pop_empty",   empty,   1);
    chk("a1_pop_rd_data", rd_data, 0);

    // Fill, overflow, drain in order, clear overrun
    for (int i = 0; i < 16; i++) push(DW'(i));
    chk("fill_full",       full,       1);
    chk("fill_level",      level,      16);
    chk("fill_thresh0",    thresh_hit, 0);
    push(8'h55);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_level",   level,   16);
    for (int i = 0; i < 16; i++) pop(DW'(i));
    chk("drain_empty",   empty,   1);
    chk("drain_overrun", overrun, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovr_clr", overrun, 0);

    // Full FIFO: push with simultaneous pop is accepted
    for (int i = 0; i < 16; i++) push(DW'(i));
    exp_q.push_back(8'h00);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("fullrw_level",   level,   16);
    chk("fullrw_full",    full,    1);
    chk("fullrw_overrun", overrun, 0);
    chk("fullrw_head",    rd_data, 8'h01);
    for (int i = 1; i < 16; i++) pop(DW'(i));
    pop(8'h77);
    chk("fullrw_empty", empty, 1);

    // Empty FIFO: lone pop ignored, push+pop keeps the byte
    step(1'b0, '0, 1'b1, 1'b0);
    chk("emptyrd_level", level, 0);
    chk("emptyrd_empty", empty, 1);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("emptyrw_level",   level,   1);
    chk("emptyrw_rd_data", rd_data, 8'h3C);
    pop(8'h3C);

    // Threshold watermark
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push(8'hB0 + DW'(i));
    chk("th3_level", level,      3);
    chk("th3_hit",   thresh_hit, 0);
    push(8'hB3);
    chk("th4_level", level,      4);
    chk("th4_hit",   thresh_hit, 1);
    pop(8'hB0);
    chk("th_pop_hit", thresh_hit, 0);
    push(8'hB4);
    chk("th_rehit", thresh_hit, 1);
    thresh = '0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("th0_hit", thresh_hit, 0);
    for (int i = 1; i < 5; i++) pop(8'hB0 + DW'(i));
    chk("th_drain_empty", empty, 1);

    // Idle timeout
`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_cycles = 32'd100;
    push(8'hD5);
    repeat (100) step(1'b0, '0, 1'b0, 1'b0);
    chk("to_100", timeout, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("to_101", timeout, 1);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    chk("to_hold", timeout, 1);
    pop(8'hD5);
    chk("to_pop", timeout, 0);
    timeout_cycles = '0;
`else
    timeout_cycles = 32'd10;
    push(8'hD5);
    repeat (40) step(1'b0, '0, 1'b0, 1'b0);
    chk("to_off", timeout, 0);
    pop(8'hD5);
    timeout_cycles = '0;
`endif

    // Drop and clear in the same cycle keeps overrun set; then reset mid-fill
    for (int i = 0; i < 16; i++) push(8'hC0 + DW'(i));
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_drop_overrun", overrun, 1);
    chk("clr_drop_level",   level,   16);
    chk("clr_drop_head",    rd_data, 8'hC0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_only_overrun", overrun, 0);
    push(8'hEF);
    chk("redrop_overrun", overrun, 1);
    thresh = 5'd2;
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk_reset_state("midrst");
    rst = 1'b0;
    thresh = '0;
    push(8'h9A);
    chk("postrst_rd_data", rd_data, 8'h9A);
    chk("postrst_level",   level,   1);
    pop(8'h9A);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the APB register file. It captures each byte completed by the receiver and holds it until the APB master reads the RX data register (offset 0x3). It exposes fill level, threshold, overrun and (optionally) idle-timeout status to the register file. It lets the master poll at a rate far below the baud rate without losing characters.

## Interface
- DATA_W, 8, byte width
- DEPTH, 16, entries; power of two, ≥ 2; AW = clog2(DEPTH) derived locally
---
- PCLK  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  one-cycle strobe from receiver: byte complete
- wr_data  in  DATA_W  received byte, valid with wr_valid
- rd_req  in  1  one-cycle pop strobe from APB access phase of a read at 0x3
- rd_data  out  DATA_W  head entry (show-ahead); 0 when empty
- empty  out  1  no entries
- full  out  1  DEPTH entries
- level  out  AW+1  current entry count, 0..DEPTH
- thresh  in  AW+1  watermark from control register
- thresh_hit  out  1  registered: thresh ≠ 0 and level ≥ thresh
- overrun  out  1  sticky: byte dropped because full
- ovr_clr  in  1  clears overrun
- timeout_cycles  in  32  idle limit in PCLK cycles; 0 disables
- timeout  out  1  non-empty FIFO idle for timeout_cycles

## Operation
- Storage: flop array, not reset. Write/read pointers AW+1 bits (extra wrap bit). empty = pointers equal; full = low bits equal, wrap bits differ.
- Push: wr_valid && (!full || rd_req) → mem[wr_ptr] = wr_data, wr_ptr++.
- Pop: rd_req && !empty → rd_ptr++. rd_req when empty: ignored, no state change.
- Simultaneous push and pop: both happen; level unchanged. When full: push accepted because a slot frees in the same cycle. When empty: push accepted, pop ignored.
- Push when full without pop: byte dropped, overrun ← 1. Overrun stays set until ovr_clr. ovr_clr and a new drop in the same cycle: overrun stays 1.
- level = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Pointers wrap naturally at 2^(AW+1).

## Timing
- Reset values: empty=1, full=0, level=0, rd_data=0, thresh_hit=0, overrun=0, timeout=0, pointers=0.
- Reset in mid-operation discards all contents in one cycle. Stored data is not cleared, but cannot be observed.
- Write latency: a byte pushed at edge N appears on rd_data, and is counted in level/empty/full, after edge N. It is visible in cycle N+1.
- Pop at edge N: the next entry is on rd_data in cycle N+1. The APB bridge samples rd_data in the same access-phase cycle that it asserts rd_req.
- thresh_hit is computed from the next-state level. It therefore changes in the same cycle as level.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined:
  - The idle counter is built.
  - The counter clears on any accepted push, any pop, when empty, or when timeout_cycles = 0. Otherwise it increments each cycle and saturates.
  - timeout asserts, registered, in the cycle after the count reaches timeout_cycles.
  - timeout holds until the next push, pop, or the FIFO going empty.
- Undefined: no counter; timeout is tied to 0; timeout_cycles is ignored.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - UART_RX_FIFO_DEPTH = 16
  - RX data register offset 0x3
  - level type
- Sub-module uart_rx_fifo_timer: the idle counter, instantiated only under UART_RX_FIFO_TIMEOUT_EN.

## Test plan
- Reset, then push 0xA1 → next cycle: rd_data=0xA1, level=1, empty=0. Pop → empty=1, rd_data=0.
- Push 0x00..0x0F (16 bytes) → full=1, level=16. Push 0x55 → overrun=1, level=16. Pop 16 times returns 0x00..0x0F in order. ovr_clr → overrun=0.
- Fill to 16, then push 0x77 with rd_req in the same cycle → 0x00 popped, 0x77 accepted, overrun=0. Subsequent pops end with 0x77.
- Empty FIFO: rd_req alone → no change. wr_valid+rd_req together → level=1, rd_data=byte.
- thresh=4: push 3 → thresh_hit=0; 4th push → thresh_hit=1 in the same cycle as level=4. thresh=0 → thresh_hit=0 always.
- With UART_RX_FIFO_TIMEOUT_EN and timeout_cycles=100: push one byte, then idle → timeout=1 after 101 cycles. Pop → timeout=0. rst asserted mid-fill → all outputs return to reset values.
